// File: rtl/sync_pkg.sv
// Shared types and the preamble symbol rule for the sync pattern transmitter and its checkers.
package sync_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SYM_NONE = 2'd0,
      SYM_K    = 2'd1,
      SYM_J    = 2'd2
   } sym_t;

   localparam int SYNC_LEN_FS = 8;
   localparam int SYNC_LEN_HS = 32;

   // K on even positions and on the final position (the closing "K K"), J otherwise.
   function automatic sym_t sync_symbol(input int unsigned idx, input int unsigned len);
      if (idx >= len) return SYM_NONE;
      if ((idx % 2) == 0 || idx == len - 1) return SYM_K;
      return SYM_J;
   endfunction

endpackage

// File: rtl/sync_pattern_tx_if.sv
// Start/strobe/abort request side and K/J symbol side of the sync pattern transmitter.
interface sync_pattern_tx_if;

   logic start;
   logic tx_en;
   logic abort;
   logic tx_k;
   logic tx_j;
   logic tx_valid;
   logic busy;
   logic sync_done_d;
   logic sync_abort_d;

   modport master (
      output start, tx_en, abort,
      input  tx_k, tx_j, tx_valid, busy, sync_done_d, sync_abort_d
   );

   modport slave (
      input  start, tx_en, abort,
      output tx_k, tx_j, tx_valid, busy, sync_done_d, sync_abort_d
   );

endinterface

// File: rtl/sync_pattern_tx.sv
// Emits (SYNC_LEN-2)/2 "K J" pairs then "K K", one symbol per tx_en strobe; first symbol the cycle after start.
// Symbols hold while tx_en=0; abort cancels in any state; all outputs decode from registers only.
import sync_pkg::*;

module sync_pattern_tx #(
   parameter int SYNC_LEN = SYNC_LEN_FS
) (
   input logic           clk,
   input logic           rst,
   sync_pattern_tx_if.slave bus
);

   localparam int              CNT_W = $clog2(SYNC_LEN);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(SYNC_LEN - 1);

   generate
      if (SYNC_LEN < 4 || SYNC_LEN > 32 || (SYNC_LEN % 2) != 0) begin : g_bad_len
         $error("sync_pattern_tx: SYNC_LEN must be even and within 4..32");
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_idx;
   logic [CNT_W-1:0] w_idx_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_abort;
   logic             w_abort_nxt;
   sym_t             w_sym;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_done  <= w_done_nxt;
         r_abort <= w_abort_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      w_abort_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               w_state_nxt = SEND;
               w_idx_nxt   = '0;
            end
         end
         SEND: begin
            // abort wins over the strobe, even on the final symbol
            if (bus.abort) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
               w_abort_nxt = 1'b1;
            end else if (bus.tx_en) begin
               if (r_idx == LAST) begin
                  w_state_nxt = IDLE;
                  w_idx_nxt   = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   assign w_sym = (r_state == SEND) ? sync_symbol(int'(r_idx), SYNC_LEN) : SYM_NONE;

   assign bus.tx_valid     = (r_state == SEND);
   assign bus.busy         = (r_state == SEND);
   assign bus.tx_k         = (w_sym == SYM_K);
   assign bus.tx_j         = (w_sym == SYM_J);
   assign bus.sync_done_d  = r_done;
   assign bus.sync_abort_d = r_abort;

endmodule

// File: doc/sync_pattern_tx.md
Name: sync_pattern_tx

Overview:
- Transmit-side counterpart of the receive sync detector in the line-coding path.
- On a start request, emits a sync preamble as K/J line symbols, one symbol per symbol strobe.
- Preamble: (SYNC_LEN-2)/2 "K J" pairs, then "K K". With the default, this is K J K J K J K K.
- Sits between the packet transmit controller (start/done handshake) and the line encoder (consumes tx_k/tx_j).

Parameters:
- SYNC_LEN, 8, preamble length in symbols. Legal values: even, 4..32. Other values are an elaboration error.
- CNT_W, $clog2(SYNC_LEN), symbol index width. Derived localparam; not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous assert, active-low (0 = reset); deasserted synchronously by the reset synchronizer upstream
- start  input  1  preamble request; sampled only in IDLE
- tx_en  input  1  symbol strobe; the current symbol is consumed in any SEND cycle where tx_en=1
- abort  input  1  cancel request; effective in any state
- tx_k  output  1  current symbol is K
- tx_j  output  1  current symbol is J
- tx_valid  output  1  tx_k/tx_j carry a preamble symbol
- busy  output  1  preamble in progress (state = SEND)
- sync_done_d  output  1  one-cycle pulse: last symbol consumed
- sync_abort_d  output  1  one-cycle pulse: preamble cancelled by abort

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, idx=0.
  - All outputs 0 immediately, regardless of clk. This includes the case where reset asserts mid-SEND.
- States: IDLE, SEND. State, idx and the two pulse flags are registered. All outputs decode from registers only (no input-to-output combinational path).
- IDLE:
  - tx_valid=tx_k=tx_j=busy=0.
  - start=1 and abort=0 → next cycle SEND, idx=0.
  - start=1 and abort=1 → stay IDLE; no pulse.
- SEND:
  - busy=1, tx_valid=1.
  - Symbol for idx: K if idx is even or idx=SYNC_LEN-1, otherwise J.
  - tx_k and tx_j are mutually exclusive. Both are 0 whenever tx_valid=0.
- Advance:
  - In SEND with tx_en=1 and abort=0: if idx<SYNC_LEN-1, idx increments.
  - If idx=SYNC_LEN-1: next cycle IDLE, idx=0, sync_done_d=1 for exactly that cycle.
  - With tx_en=0 the symbol and idx are held indefinitely. There is no timeout.
- Abort:
  - In SEND, abort=1 overrides tx_en, including on the last symbol.
  - Next cycle IDLE, outputs 0, sync_abort_d=1 for one cycle; sync_done_d stays 0.
  - In IDLE, abort only suppresses start; it does not pulse.
- Latency:
  - start accepted at edge N → first K visible in cycle N+1.
  - With tx_en held at 1, sync_done_d is high in cycle N+1+SYNC_LEN.
- Back-to-back: the cycle carrying sync_done_d or sync_abort_d is IDLE, so start in that cycle is accepted. The next preamble begins the following cycle.
- start while busy: ignored; not queued.
- idx width: CNT_W bits, never wraps. The terminal compare is against SYNC_LEN-1.

Decomposition:
- Package sync_pkg holds:
  - state typedef (IDLE, SEND)
  - symbol typedef (SYM_NONE, SYM_K, SYM_J)
  - SYNC_LEN_FS=8 and SYNC_LEN_HS=32 constants
  - function sync_symbol(idx, len) returning the symbol; this function is shared with the receiver-side checker in the bench
- No sub-module: a single FSM plus counter; a split adds nothing.

Test Plan:
- Async reset: drive rst=0 mid-SEND (idx=3) between clock edges → tx_valid, tx_k, tx_j, busy = 0 before the next edge; after release, state is IDLE and no pulse fires.
- Full preamble, SYNC_LEN=8, tx_en=1 constantly: start at edge 0 → cycles 1..8 show tx_k/tx_j = K J K J K J K K with tx_valid=1; cycle 9 shows sync_done_d=1 and busy=0.
- Gapped strobe: tx_en=1 every other cycle → each symbol held exactly 2 cycles; sequence unchanged; sync_done_d after 16 SEND cycles.
- Abort at idx=3 with tx_en=1 → next cycle tx_valid=0, sync_abort_d=1 for one cycle, sync_done_d never asserts; start in the pulse cycle gives K at the next cycle.
- start held high throughout: no retrigger while busy; a new preamble starts immediately after the sync_done_d cycle. start=abort=1 in IDLE → remains IDLE, no pulses.
- SYNC_LEN=32, tx_en=1: 15 K J pairs then K K; sync_done_d 33 cycles after start; output matches sync_symbol() every cycle.
